ctrl_interrup: RTL and testbench
================================

Name: ctrl_interrup

Overview:
- Interrupt controller for the monocycle CPU with I/O ports; drives the CPU's s_interrup input and consumes its finInterrup output (other end of the interrupt handshake).
- Synchronises and edge-detects external request lines, latches them as pending, arbitrates by fixed priority, and supplies the vector address the datapath loads into PC during the s_interrup cycle.
- No nesting: one interrupt is in service at a time.

Parameters:
- N_SRC, 4, number of request lines (1..8).
- PC_W, 10, width of vector/PC.
- VEC_BASE, 10'h3C0, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive source vectors.
- TIMER_PERIOD, 1000, timer period in clk cycles (used only with TIMER_IRQ_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq  in  N_SRC  external request lines, asynchronous, rising-edge sensitive.
- irq_mask  in  N_SRC  1 = source enabled for dispatch.
- finInterrup  in  1  from CPU: return-from-interrupt executed, high for 1 cycle.
- s_interrup  out  1  to CPU: take interrupt now, high for exactly 1 cycle.
- vector  out  PC_W  jump target for the in-service source.
- busy  out  1  high from REQ through DONE.
- pending  out  N_SRC  latched pending flags.
- in_service  out  3  index of the source being serviced.

Behaviour:
- Reset (async): s_interrup=0, busy=0, pending=0, in_service=0, vector=VEC_BASE, all sync flops 0, FSM=IDLE.
- Input path: per line, 2-flop synchroniser (s1, s2) plus history flop s3. Rising edge = s2 & ~s3.
- Pending: bit i is set on an edge of line i regardless of mask. It is cleared only in DONE for in_service. If a set and a clear coincide, the set wins.
- Arbitration: candidates = pending & irq_mask. Lowest index wins.
- FSM states: IDLE, REQ, SERVICE, DONE.
- IDLE: if candidates != 0, latch in_service = winner, latch vector = VEC_BASE + winner*VEC_STRIDE (mod 2^PC_W), go to REQ.
- REQ: s_interrup=1 and busy=1 for this single cycle. Next state SERVICE unconditionally.
- SERVICE: busy=1, s_interrup=0. Wait for finInterrup=1, then go to DONE. finInterrup in any other state is ignored.
- DONE: busy=1. Clear pending[in_service], subject to set-wins. Next state IDLE. The one-cycle guard ensures the CPU's pop completes before the next dispatch.
- Latency: irq first sampled high at edge E1 gives pending set at E3, state REQ at E4, and s_interrup high in the cycle after E4. Back-to-back: the next s_interrup comes 2 cycles after finInterrup (DONE, IDLE, REQ).
- Masking during SERVICE does not abort service. A masked pending source stays pending and is dispatched once unmasked.
- vector and in_service are held stable from REQ until the next IDLE dispatch.
- Outputs are registered. No combinational path from irq or finInterrup to s_interrup.
- Reset asserted mid-service: immediate return to IDLE, all pending lost.

Optional Feature:
- Macro TIMER_IRQ_EN.
- Defined: internal counter 0..TIMER_PERIOD-1, which wraps and produces a 1-cycle tick. The tick ORs into the edge-detect output of source N_SRC-1 (lowest priority), bypassing the synchroniser. The counter resets to 0 on reset.
- Undefined: no counter, and source N_SRC-1 is driven by irq only.

Test Plan:
- Reset mid-SERVICE with pending=4'b0110 -> s_interrup=0, busy=0, pending=0, vector=10'h3C0 during reset.
- irq=4'b0100 pulse held 3 cycles, mask=4'b1111 -> s_interrup high 1 cycle after E4, vector=10'h3C8, in_service=2; finInterrup pulse -> pending[2]=0, busy low 2 cycles later.
- irq[3] and irq[1] rise together -> source 1 first (vector 10'h3C4); after finInterrup, source 3 (vector 10'h3CC) with s_interrup 2 cycles after finInterrup.
- mask=4'b1110, irq[0] edge -> pending=4'b0001, no s_interrup for 20 cycles; set mask=4'b1111 -> dispatch with vector 10'h3C0.
- In SERVICE for source 2, new irq[2] edge whose pending set lands on the DONE cycle -> pending[2] remains 1, second dispatch of source 2.
- TIMER_IRQ_EN, TIMER_PERIOD=8, no irq -> s_interrup every dispatch with vector 10'h3CC, with finInterrup answered promptly the period is 8 cycles.

Source files
------------

// File: rtl/ctrl_interrup.sv
// Interrupt controller: sync + edge-detect irq lines, fixed-priority dispatch, one-cycle s_interrup pulse and vector to the CPU.
// Optional TIMER_IRQ_EN adds a periodic tick on source N_SRC-1; irq edge to s_interrup is 4 cycles, no nesting.
module ctrl_interrup #(
  parameter int              N_SRC        = 4,
  parameter int              PC_W         = 10,
  parameter logic [PC_W-1:0] VEC_BASE     = 10'h3C0,
  parameter int              VEC_STRIDE   = 4,
  parameter int              TIMER_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             finInterrup,
  output logic             s_interrup,
  output logic [PC_W-1:0]  vector,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic [2:0]       in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_s1, r_s2, r_s3;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_cand;
  logic [N_SRC-1:0] w_clr;
  logic [2:0]       w_winner;
  logic             w_any;
  logic [PC_W-1:0]  w_vec;
  logic             w_tick;
  logic [2:0]       r_in_service;
  logic [PC_W-1:0]  r_vector;
  logic             r_s_interrup;
  logic             r_busy;

`ifdef TIMER_IRQ_EN
  localparam int TMR_W = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
  logic [TMR_W-1:0] r_tmr_cnt;

  assign w_tick = (r_tmr_cnt == TMR_W'(TIMER_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_cnt <= '0;
    end else if (w_tick) begin
      r_tmr_cnt <= '0;
    end else begin
      r_tmr_cnt <= r_tmr_cnt + 1'b1;
    end
  end
`else
  assign w_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // The timer tick skips the synchroniser: it is already in the clk domain.
  always_comb begin
    w_edge           = r_s2 & ~r_s3;
    w_edge[N_SRC-1]  = w_edge[N_SRC-1] | w_tick;
  end

  assign w_cand = r_pending & irq_mask;
  assign w_any  = |w_cand;

  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = 3'(i);
    end
  end

  assign w_vec = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(w_winner);

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_clr[i] = (r_state == DONE) && (r_in_service == 3'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = REQ;
      REQ:     w_state_nxt = SERVICE;
      SERVICE: if (finInterrup) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Set after clear so a new edge landing on the DONE cycle is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_in_service <= '0;
      r_vector     <= VEC_BASE;
      r_s_interrup <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= (r_pending & ~w_clr) | w_edge;
      r_s_interrup <= (w_state_nxt == REQ);
      r_busy       <= (w_state_nxt != IDLE);
      if (r_state == IDLE && w_any) begin
        r_in_service <= w_winner;
        r_vector     <= w_vec;
      end
    end
  end

  assign s_interrup = r_s_interrup;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign vector     = r_vector;

endmodule

// File: tb/tb_ctrl_interrup.sv
// Directed bench for ctrl_interrup; build with TIMER_IRQ_EN defined to exercise the timer source instead.
module tb_ctrl_interrup;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic [3:0] irq_mask;
  logic       finInterrup;
  logic       s_interrup;
  logic [9:0] vector;
  logic       busy;
  logic [3:0] pending;
  logic [2:0] in_service;

  int n_chk = 0;
  int n_err = 0;

  ctrl_interrup #(
    .N_SRC(4), .PC_W(10), .VEC_BASE(10'h3C0), .VEC_STRIDE(4), .TIMER_PERIOD(8)
  ) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask),
    .finInterrup(finInterrup), .s_interrup(s_interrup), .vector(vector),
    .busy(busy), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sint(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_interrup && n < max);
    if (!s_interrup) chk("sint_timeout", 32'd0, 32'd1);
  endtask

  // Called from a SERVICE-cycle negedge; returns at the IDLE negedge.
  task automatic finish_svc;
    finInterrup = 1'b1;
    cyc(1);
    finInterrup = 1'b0;
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    reset = 1'b1; irq = 4'b0000; irq_mask = 4'b1111; finInterrup = 1'b0;
    cyc(2);
    chk("rst_sint", 32'(s_interrup), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_vec", 32'(vector), 32'h3C0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    reset = 1'b0;

`ifdef TIMER_IRQ_EN
    wait_sint(20, n);
    chk("tmr_vec0", 32'(vector), 32'h3CC);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      finish_svc();
      wait_sint(20, n);
      chk("tmr_period", 32'(3 + n), 32'd8);
      chk("tmr_vec", 32'(vector), 32'h3CC);
    end
`else
    // Reset while source 1 is in service and source 2 still pending.
    irq = 4'b0110;
    wait_sint(10, n);
    chk("mid_vec", 32'(vector), 32'h3C4);
    cyc(2);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_pend", 32'(pending), 32'h6);
    reset = 1'b1;
    #1;
    chk("mid_rst_sint", 32'(s_interrup), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'h0);
    chk("mid_rst_vec", 32'(vector), 32'h3C0);
    irq = 4'b0000;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    chk("post_rst_pend", 32'(pending), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single source, exact latency.
    irq = 4'b0100;
    cyc(3);
    chk("lat_pend_e3", 32'(pending), 32'h4);
    chk("lat_sint_e3", 32'(s_interrup), 32'd0);
    irq = 4'b0000;
    cyc(1);
    chk("lat_sint_e4", 32'(s_interrup), 32'd1);
    chk("lat_vec", 32'(vector), 32'h3C8);
    chk("lat_insvc", 32'(in_service), 32'd2);
    chk("lat_busy_req", 32'(busy), 32'd1);
    cyc(1);
    chk("lat_sint_pulse", 32'(s_interrup), 32'd0);
    chk("lat_busy_svc", 32'(busy), 32'd1);
    finInterrup = 1'b1;
    cyc(1);
    finInterrup = 1'b0;
    chk("lat_busy_done", 32'(busy), 32'd1);
    chk("lat_pend_done", 32'(pending), 32'h4);
    cyc(1);
    chk("lat_pend_clr", 32'(pending), 32'h0);
    chk("lat_busy_idle", 32'(busy), 32'd0);

    // Simultaneous edges: lowest index first, then back-to-back.
    irq = 4'b1010;
    cyc(4);
    chk("pri_sint1", 32'(s_interrup), 32'd1);
    chk("pri_vec1", 32'(vector), 32'h3C4);
    chk("pri_insvc1", 32'(in_service), 32'd1);
    cyc(1);
    finInterrup = 1'b1;
    cyc(1);
    finInterrup = 1'b0;
    chk("b2b_sint_done", 32'(s_interrup), 32'd0);
    cyc(1);
    chk("b2b_sint_idle", 32'(s_interrup), 32'd0);
    chk("b2b_pend", 32'(pending), 32'h8);
    cyc(1);
    chk("b2b_sint", 32'(s_interrup), 32'd1);
    chk("b2b_vec", 32'(vector), 32'h3CC);
    chk("b2b_insvc", 32'(in_service), 32'd3);
    irq = 4'b0000;
    cyc(1);
    finish_svc();
    chk("b2b_pend_clr", 32'(pending), 32'h0);

    // Masked source stays pending until unmasked.
    irq_mask = 4'b1110;
    irq = 4'b0001;
    cyc(4);
    chk("mask_pend", 32'(pending), 32'h1);
    irq = 4'b0000;
    cnt = 0;
    repeat (20) begin
      cyc(1);
      if (s_interrup) cnt++;
    end
    chk("mask_no_sint", 32'(cnt), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    irq_mask = 4'b1111;
    cyc(1);
    chk("unmask_sint", 32'(s_interrup), 32'd1);
    chk("unmask_vec", 32'(vector), 32'h3C0);
    cyc(1);
    finish_svc();
    chk("unmask_pend_clr", 32'(pending), 32'h0);

    // New edge on the in-service source lands on the DONE cycle.
    irq = 4'b0100;
    wait_sint(8, n);
    chk("sw_latency", 32'(n), 32'd4);
    chk("sw_vec1", 32'(vector), 32'h3C8);
    irq = 4'b0000;
    cyc(3);
    irq = 4'b0100;
    cyc(1);
    finInterrup = 1'b1;
    cyc(1);
    finInterrup = 1'b0;
    chk("sw_pend_done", 32'(pending), 32'h4);
    cyc(1);
    chk("sw_set_wins", 32'(pending), 32'h4);
    chk("sw_busy_idle", 32'(busy), 32'd0);
    cyc(1);
    chk("sw_sint2", 32'(s_interrup), 32'd1);
    chk("sw_vec2", 32'(vector), 32'h3C8);
    irq = 4'b0000;
    cyc(1);
    finish_svc();
    chk("sw_pend_clr", 32'(pending), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
